light_pattern_ctrl: RTL and testbench
=====================================

# light_pattern_ctrl

Drives the board LED bank with selectable visual patterns. Sits directly downstream of the free-running light/time generator: consumes its slow blink level (`i_on`, about 0.67 Hz) and its ~47.7 Hz square wave (`i_sqrwave`), and converts the square-wave rising edges into a pattern-step tick. Mode is chosen by the top-level control FSM through a one-cycle load strobe; output feeds the LEDR pins directly.

## Interface
- `N_LED`, default 18: number of LEDs driven; must be ≥ 2.
- `PWM_BITS`, default 6: width of the breathe duty and PWM counter.
- `CHASE_DIV`, default 4: number of ticks per chase/bounce step; must be ≥ 1.
- `i_clk` in 1: system clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_sqrwave` in 1: ~47.7 Hz square wave, synchronous to `i_clk`.
- `i_on` in 1: slow blink level, synchronous to `i_clk`.
- `i_mode` in 3: requested mode code, sampled only when `i_mode_load`=1.
- `i_mode_load` in 1: one-cycle strobe to apply `i_mode`.
- `o_led` out N_LED: registered LED drive; bit 0 is the rightmost LED.
- `o_step` out 1: one-cycle pulse when the pattern advances (position or duty changes).
- `o_mode` out 3: currently active mode code.

## Operation
- Tick: rising-edge detect on `i_sqrwave`. `tick` = `i_sqrwave` & ~`sq_prev`. `sq_prev` resets to 0, so the first rising edge after reset produces a tick.
- Mode codes:
  - 0 OFF: all LEDs 0.
  - 1 SOLID: all LEDs 1.
  - 2 BLINK: all LEDs equal `i_on`.
  - 3 CHASE: one-hot at `pos`. Steps +1 every CHASE_DIV ticks and wraps from N_LED-1 to 0.
  - 4 BOUNCE: one-hot at `pos`. Moves up to N_LED-1, then down to 0, then repeats. Endpoints are shown for one step only: the sequence is ...N-2, N-1, N-2...
  - 5 BREATHE: all LEDs equal (`pwm_cnt` < `duty`). `duty` moves by 1 per tick, ramping 0 up to 2^PWM_BITS-1, then down to 0, then repeats. Direction flips at each end.
  - 6, 7: reserved. A load with these codes is ignored; mode and all state are retained.
- Load with a valid code, including the current mode:
  - `mode` ← `i_mode`, `pos` ← 0, `dir` ← up, `duty` ← 0, `div_cnt` ← 0.
  - A tick in the same cycle is discarded.
- `div_cnt` counts ticks 0 to CHASE_DIV-1 in CHASE/BOUNCE only. A step occurs on the tick where `div_cnt` = CHASE_DIV-1; `div_cnt` then wraps to 0.
- `pwm_cnt` is a free-running PWM_BITS counter on `i_clk` in every mode and wraps naturally. With `duty`=0 the output is always off; the maximum duty gives (2^PWM_BITS-1)/2^PWM_BITS on.
- In OFF/SOLID/BLINK, ticks are ignored and `pos`/`duty`/`div_cnt` hold.
- `o_step` pulses in the cycle after the register update, aligned with the `o_led` change.

## Timing
- Reset values:
  - `o_led` = 0, `o_step` = 0, `o_mode` = 0 (OFF).
  - `pos` = 0, `dir` = up, `duty` = 0, `div_cnt` = 0, `pwm_cnt` = 0, `sq_prev` = 0.
- `o_led` is registered: the value after edge n+1 is a function of the state and of `i_on` after edge n.
- Mode load latency:
  - Strobe high before edge n: `o_mode` updates at edge n.
  - The new pattern appears on `o_led` at edge n+1. CHASE/BOUNCE show LED0 at edge n+1.
- Tick latency: `i_sqrwave` rises before edge n → `sq_prev` and `pos`/`duty` update at edge n → `o_led` and `o_step` update at edge n+1.
- BLINK: a change on `i_on` reaches `o_led` in 1 cycle.
- Reset mid-pattern: all state and outputs clear immediately (asynchronous). Operation resumes in OFF; a fresh load is needed.
- Widths: `pos` is $clog2(N_LED) bits; `div_cnt` is $clog2(CHASE_DIV)+1 bits. All comparisons are unsigned.

## Structure
- Shared package `light_pkg`:
  - `light_mode_e` enum (3-bit: OFF, SOLID, BLINK, CHASE, BOUNCE, BREATHE).
  - `DIR_UP`/`DIR_DN` constants.
  - Default parameter constants.
- One sub-module `rise_detect`: a registered rising-edge detector with async active-low reset, producing a 1-cycle pulse. Reusable for key inputs.
- Remaining logic (mode register, step counters, PWM comparator, output register) lives in `light_pattern_ctrl`.

## Test plan
- **Reset:** hold reset low, toggle `i_sqrwave` → `o_led`=0, `o_mode`=0, `o_step` never pulses.
- **Chase wrap:** load 3 and apply 4×18 ticks (CHASE_DIV=4) → `o_led` goes 0x00001, 0x00002, … 0x20000, then 0x00001. Exactly 18 `o_step` pulses, each after every 4th tick.
- **Bounce:** load 4 and apply 34 steps → `pos` sequence 0..17..1 then 0, with no repeated endpoint.
- **Breathe:** load 5 and apply 63 ticks → `duty`=63, and `o_led` is high for 63 of 64 cycles. 63 more ticks → `duty`=0, and `o_led` stays low for a full PWM period.
- **Load edge cases:**
  - Load 6 mid-CHASE → pattern unchanged.
  - Load 3 mid-CHASE, with a tick in the same cycle → `pos`=0 and no `o_step`.
  - Load 2 → `o_led` tracks `i_on` with 1-cycle delay.
- **Async reset:** assert reset mid-BREATHE at `duty`=30 → all outputs 0 immediately. After release, a tick in OFF leaves `o_led`=0.

Source files
------------

// File: rtl/light_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | light_pkg                                                            |
// | Shared mode codes, direction constants and defaults for LED patterns |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package light_pkg;

    typedef enum logic [2:0] {
        MODE_OFF     = 3'd0,
        MODE_SOLID   = 3'd1,
        MODE_BLINK   = 3'd2,
        MODE_CHASE   = 3'd3,
        MODE_BOUNCE  = 3'd4,
        MODE_BREATHE = 3'd5
    } light_mode_e;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    localparam int DEF_N_LED     = 18;
    localparam int DEF_PWM_BITS  = 6;
    localparam int DEF_CHASE_DIV = 4;

    // Codes 6 and 7 are reserved and must not be loaded.
    function automatic logic mode_is_valid(input logic [2:0] code);
        return (code <= 3'd5);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rise_detect                                                          |
// | Registered rising-edge detector, one-cycle pulse output              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rise_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise
);

    logic prev_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= i_d;
        end
    end

    assign o_rise = i_d & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/light_pattern_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | light_pattern_ctrl                                                   |
// | LED bank pattern generator: off/solid/blink/chase/bounce/breathe     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module light_pattern_ctrl
    import light_pkg::*;
#(
    parameter int N_LED     = DEF_N_LED,
    parameter int PWM_BITS  = DEF_PWM_BITS,
    parameter int CHASE_DIV = DEF_CHASE_DIV
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sqrwave,
    input  logic             i_on,
    input  logic [2:0]       i_mode,
    input  logic             i_mode_load,
    output logic [N_LED-1:0] o_led,
    output logic             o_step,
    output logic [2:0]       o_mode
);

    localparam int POS_W = $clog2(N_LED);
    localparam int DIV_W = $clog2(CHASE_DIV) + 1;

    localparam logic [POS_W-1:0]    POS_LAST = POS_W'(N_LED - 1);
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CHASE_DIV - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
    localparam logic [N_LED-1:0]    LED_ONE  = N_LED'(1);

    light_mode_e         mode_q, mode_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                dir_q, dir_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [PWM_BITS-1:0] pwm_q;
    logic [N_LED-1:0]    led_q, led_d;
    logic                adv_q, adv_d;
    logic                step_q;

    logic w_tick;
    logic w_load_ok;

    rise_detect u_sq_rise (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_sqrwave),
        .o_rise  (w_tick)
    );

    assign w_load_ok = i_mode_load & mode_is_valid(i_mode);

    // A valid load restarts the pattern and swallows a coincident tick.
    always_comb begin
        mode_d = mode_q;
        pos_d  = pos_q;
        dir_d  = dir_q;
        duty_d = duty_q;
        div_d  = div_q;
        adv_d  = 1'b0;
        if (w_load_ok) begin
            mode_d = light_mode_e'(i_mode);
            pos_d  = '0;
            dir_d  = DIR_UP;
            duty_d = '0;
            div_d  = '0;
        end else if (w_tick) begin
            case (mode_q)
                MODE_CHASE, MODE_BOUNCE: begin
                    if (div_q == DIV_LAST) begin
                        div_d = '0;
                        adv_d = 1'b1;
                        if (mode_q == MODE_CHASE) begin
                            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
                        end else if (dir_q == DIR_UP) begin
                            if (pos_q == POS_LAST) begin
                                pos_d = pos_q - 1'b1;
                                dir_d = DIR_DN;
                            end else begin
                                pos_d = pos_q + 1'b1;
                            end
                        end else begin
                            if (pos_q == '0) begin
                                pos_d = POS_W'(1);
                                dir_d = DIR_UP;
                            end else begin
                                pos_d = pos_q - 1'b1;
                            end
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                MODE_BREATHE: begin
                    adv_d = 1'b1;
                    if (dir_q == DIR_UP) begin
                        if (duty_q == DUTY_MAX) begin
                            duty_d = duty_q - 1'b1;
                            dir_d  = DIR_DN;
                        end else begin
                            duty_d = duty_q + 1'b1;
                        end
                    end else begin
                        if (duty_q == '0) begin
                            duty_d = PWM_BITS'(1);
                            dir_d  = DIR_UP;
                        end else begin
                            duty_d = duty_q - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        led_d = '0;
        case (mode_q)
            MODE_SOLID:              led_d = '1;
            MODE_BLINK:              led_d = {N_LED{i_on}};
            MODE_CHASE, MODE_BOUNCE: led_d = LED_ONE << pos_q;
            MODE_BREATHE:            led_d = {N_LED{pwm_q < duty_q}};
            default:                 led_d = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_q <= MODE_OFF;
            pos_q  <= '0;
            dir_q  <= DIR_UP;
            duty_q <= '0;
            div_q  <= '0;
            pwm_q  <= '0;
            led_q  <= '0;
            adv_q  <= 1'b0;
            step_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            duty_q <= duty_d;
            div_q  <= div_d;
            pwm_q  <= pwm_q + 1'b1;
            led_q  <= led_d;
            adv_q  <= adv_d;
            step_q <= adv_q;
        end
    end

    assign o_led  = led_q;
    assign o_step = step_q;
    assign o_mode = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_light_pattern_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_light_pattern_ctrl                                                |
// | Self-checking bench with an arithmetic pattern model                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_light_pattern_ctrl;

    localparam int N    = 18;
    localparam int D    = 4;
    localparam int PB   = 6;
    localparam int DMAX = (1 << PB) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sq = 1'b0;
    logic         on = 1'b0;
    logic         load = 1'b0;
    logic [2:0]   mode_in = 3'd0;
    logic [N-1:0] o_led;
    logic         o_step;
    logic [2:0]   o_mode;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: pattern position/duty derived from ticks counted since the last load.
    int m_mode, m_ticks, m_pwm, step_pulses, high_cnt;
    bit m_sqprev, m_adv;

    light_pattern_ctrl #(.N_LED(N), .PWM_BITS(PB), .CHASE_DIV(D)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sqrwave   (sq),
        .i_on        (on),
        .i_mode      (mode_in),
        .i_mode_load (load),
        .o_led       (o_led),
        .o_step      (o_step),
        .o_mode      (o_mode)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] model_led(int md, int t, int pwm, bit on_v);
        logic [N-1:0] one;
        int steps, p, pos, duty;
        one = 1;
        case (md)
            1: return '1;
            2: return on_v ? '1 : '0;
            3: begin
                steps = t / D;
                pos   = steps % N;
                return one << pos;
            end
            4: begin
                steps = t / D;
                p     = steps % (2 * N - 2);
                pos   = (p < N) ? p : (2 * N - 2 - p);
                return one << pos;
            end
            5: begin
                p    = t % (2 * DMAX);
                duty = (p <= DMAX) ? p : (2 * DMAX - p);
                return (pwm < duty) ? '1 : '0;
            end
            default: return '0;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ticks = 0; m_pwm = 0; m_sqprev = 0; m_adv = 0;
    endtask

    task automatic cyc(input bit s, input bit o, input bit ld, input logic [2:0] code);
        logic [N-1:0] e_led;
        bit e_step, tk;
        sq = s; on = o; load = ld; mode_in = code;
        @(posedge clk);
        e_led  = model_led(m_mode, m_ticks, m_pwm, o);
        e_step = m_adv;
        tk = s & !m_sqprev;
        m_sqprev = s;
        m_pwm = (m_pwm + 1) % (1 << PB);
        m_adv = 0;
        if (ld && code <= 3'd5) begin
            m_mode  = int'(code);
            m_ticks = 0;
        end else if (tk && m_mode >= 3 && m_mode <= 5) begin
            m_ticks++;
            m_adv = (m_mode == 5) || (m_ticks % D == 0);
        end
        #1;
        check_val("led", o_led, e_led);
        check_val("step", o_step, e_step);
        check_val("mode", o_mode, m_mode[2:0]);
        if (o_step) step_pulses++;
        if (o_led[0]) high_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 3'd0);
            cyc(1'b0, 1'b0, 1'b0, 3'd0);
        end
    endtask

    initial begin
        model_reset();
        step_pulses = 0;
        high_cnt = 0;

        // Held in reset with the square wave toggling.
        for (int i = 0; i < 8; i++) begin
            sq = ~sq;
            @(posedge clk);
            #1;
            check_val("rst_led", o_led, 0);
            check_val("rst_mode", o_mode, 0);
            check_val("rst_step", o_step, 0);
        end
        rst_n = 1'b1;
        model_reset();
        ticks(3);

        // Chase wrap.
        cyc(1'b0, 1'b0, 1'b1, 3'd3);
        step_pulses = 0;
        ticks(N * D);
        check_val("chase_steps", step_pulses, N);
        check_val("chase_wrap", o_led, 1);

        // Bounce full cycle.
        cyc(1'b0, 1'b0, 1'b1, 3'd4);
        step_pulses = 0;
        ticks(34 * D);
        check_val("bounce_steps", step_pulses, 34);
        check_val("bounce_home", o_led, 1);

        // Breathe top and bottom.
        cyc(1'b0, 1'b0, 1'b1, 3'd5);
        ticks(DMAX);
        high_cnt = 0;
        for (int i = 0; i < 64; i++) cyc(1'b0, 1'b0, 1'b0, 3'd0);
        check_val("breathe_max_on", high_cnt, 63);
        ticks(DMAX);
        high_cnt = 0;
        for (int i = 0; i < 64; i++) cyc(1'b0, 1'b0, 1'b0, 3'd0);
        check_val("breathe_zero_on", high_cnt, 0);

        // Load edge cases.
        cyc(1'b0, 1'b0, 1'b1, 3'd3);
        ticks(10);
        cyc(1'b0, 1'b0, 1'b1, 3'd6);
        cyc(1'b0, 1'b0, 1'b1, 3'd7);
        ticks(3);
        cyc(1'b1, 1'b0, 1'b1, 3'd3);
        cyc(1'b1, 1'b0, 1'b0, 3'd0);
        check_val("reload_pos0", o_led, 1);
        check_val("reload_nostep", o_step, 0);
        cyc(1'b0, 1'b0, 1'b1, 3'd2);
        for (int i = 0; i < 20; i++) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 3'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 199) == 0), 3'($urandom_range(0, 7)));
        end

        // Asynchronous reset mid-breathe at duty 30.
        cyc(1'b0, 1'b0, 1'b1, 3'd5);
        ticks(30);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_led", o_led, 0);
        check_val("arst_mode", o_mode, 0);
        check_val("arst_step", o_step, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        ticks(4);
        check_val("off_after_rst", o_led, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
